hwpe_ctrl_uloop: RTL



---
 rtl/hwpe_ctrl_uloop.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/hwpe_ctrl_uloop.sv
// rtl/hwpe_ctrl_uloop.sv - loop-nest microcode sequencer emitting handshaked iteration points
module hwpe_ctrl_uloop #(
  parameter int unsigned LENGTH    = 16,
  parameter int unsigned NB_LOOPS  = 6,
  parameter int unsigned NB_REG    = 4,
  parameter int unsigned NB_RO_REG = 8,
  parameter int unsigned REG_WIDTH = 32,
  parameter int unsigned CNT_WIDTH = 16
) (
  input  logic                                                  clk_i,
  input  logic                                                  rst_i,
  input  logic                                                  start_i,
  input  logic                                                  abort_i,
  input  logic [NB_LOOPS-1:0][CNT_WIDTH-1:0]                    range_i,
  input  logic [NB_LOOPS-1:0][$clog2(LENGTH)-1:0]               loop_addr_i,
  input  logic [NB_LOOPS-1:0][$clog2(LENGTH):0]                 loop_nb_ops_i,
  input  logic [LENGTH-1:0]                                     code_op_sel_i,
  input  logic [LENGTH-1:0][$clog2(NB_REG)-1:0]                 code_a_i,
  input  logic [LENGTH-1:0][$clog2(NB_REG+NB_RO_REG)-1:0]       code_b_i,
  input  logic [NB_RO_REG-1:0][REG_WIDTH-1:0]                   registers_read_i,
  output logic                                                  valid_o,
  input  logic                                                  ready_i,
  output logic [NB_REG-1:0][REG_WIDTH-1:0]                      offs_o,
  output logic [NB_LOOPS-1:0][CNT_WIDTH-1:0]                    idx_o,
  output logic [NB_LOOPS-1:0]                                   last_o,
  output logic                                                  busy_o,
  output logic                                                  done_o
);

  localparam int AW = $clog2(LENGTH);
  localparam int BW = $clog2(NB_REG + NB_RO_REG);
  localparam int LW = (NB_LOOPS > 1) ? $clog2(NB_LOOPS) : 1;

  typedef enum logic [1:0] {IDLE, EMIT, EXEC, DONE} state_t;

  state_t                              state_q, state_d;
  logic [NB_REG-1:0][REG_WIDTH-1:0]    regs_q;
  logic [NB_LOOPS-1:0][CNT_WIDTH-1:0]  idx_q;
  logic [AW-1:0]                       addr_q;
  logic [AW:0]                         op_q;
  logic [LW-1:0]                       cur_q;

  logic [NB_LOOPS-1:0]                 at_end;
  logic [NB_LOOPS-1:0]                 last_all;
  logic [LW-1:0]                       sel_loop;
  logic                                found;
  logic [BW-1:0]                       cur_b;
  logic [REG_WIDTH-1:0]                opnd;
  logic [REG_WIDTH-1:0]                result;
  logic                                step_done;
  logic                                nest_end;

  // a range of 0 behaves as a single iteration
  always_comb begin
    at_end = '0;
    for (int j = 0; j < NB_LOOPS; j++) begin
      if (range_i[j] == '0) at_end[j] = (idx_q[j] == '0);
      else                  at_end[j] = (idx_q[j] == range_i[j] - 1'b1);
    end
  end

  always_comb begin
    last_all = '0;
    last_all[0] = at_end[0];
    for (int j = 1; j < NB_LOOPS; j++) last_all[j] = last_all[j-1] & at_end[j];
  end

  always_comb begin
    sel_loop = '0;
    found    = 1'b0;
    for (int j = 0; j < NB_LOOPS; j++) begin
      if (!found && !last_all[j]) begin
        sel_loop = LW'(j);
        found    = 1'b1;
      end
    end
  end

  assign nest_end  = last_all[NB_LOOPS-1];
  assign cur_b     = code_b_i[addr_q];
  assign step_done = ((op_q + 1'b1) == loop_nb_ops_i[cur_q]);

  // operand indices past the read-only bank read as zero
  always_comb begin
    opnd = '0;
    for (int i = 0; i < NB_REG; i++)
      if (cur_b == BW'(i)) opnd = regs_q[i];
    for (int i = 0; i < NB_RO_REG; i++)
      if (cur_b == BW'(NB_REG + i)) opnd = registers_read_i[i];
  end

  assign result = code_op_sel_i[addr_q] ? regs_q[code_a_i[addr_q]] + opnd : opnd;

  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (start_i) state_d = EMIT;
      EMIT: begin
        if (ready_i) begin
          if (nest_end)                             state_d = DONE;
          else if (loop_nb_ops_i[sel_loop] == '0)   state_d = EMIT;
          else                                      state_d = EXEC;
        end
      end
      EXEC: if (step_done) state_d = EMIT;
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (abort_i) state_d = IDLE;
  end

  always_comb begin
    valid_o = (state_q == EMIT);
    busy_o  = (state_q != IDLE);
    done_o  = (state_q == DONE);
    last_o  = (state_q == EMIT) ? last_all : '0;
    offs_o  = regs_q;
    idx_o   = idx_q;
  end

  // abort freezes the datapath so the last point's contents stay visible
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      regs_q <= '0;
      idx_q  <= '0;
      addr_q <= '0;
      op_q   <= '0;
      cur_q  <= '0;
    end else if (!abort_i) begin
      case (state_q)
        IDLE: begin
          if (start_i) begin
            regs_q <= '0;
            idx_q  <= '0;
          end
        end
        EMIT: begin
          if (ready_i && !nest_end) begin
            for (int j = 0; j < NB_LOOPS; j++)
              if (j < int'(sel_loop)) idx_q[j] <= '0;
            idx_q[sel_loop] <= idx_q[sel_loop] + 1'b1;
            addr_q <= loop_addr_i[sel_loop];
            op_q   <= '0;
            cur_q  <= sel_loop;
          end
        end
        EXEC: begin
          regs_q[code_a_i[addr_q]] <= result;
          addr_q <= (addr_q == AW'(LENGTH - 1)) ? '0 : addr_q + 1'b1;
          op_q   <= op_q + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
